dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access for the MEM stage. Shares the single data-memory port between two requesters: the pipeline (driven by the EX/MEM register outputs) and the debug/program-loader port.
- Models a fixed multi-cycle memory latency. Stalls the pipeline until each pipeline access completes.
- Sits between the EX/MEM register, the data memory and the MEM/WB register. Its stall output freezes PC, IF/ID, ID/EX and EX/MEM.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory latency in cycles, counted from the grant edge to completion; legal values >= 1

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- pipe_memread  in  1  pipeline load request (EX/MEM memread_out)
- pipe_memwrite  in  1  pipeline store request (EX/MEM memwrite_out)
- pipe_addr  in  ADDR_W  pipeline address (EX/MEM alu_result_out)
- pipe_wdata  in  DATA_W  pipeline store data (EX/MEM read_data2_out)
- pipe_rdata  out  DATA_W  load data to MEM/WB; valid only when pipe_done=1
- pipe_done  out  1  completion cycle of a pipeline access
- stall  out  1  freeze upstream pipeline registers and PC
- dbg_req  in  1  debug request, level; held until dbg_ack
- dbg_we  in  1  debug write enable
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_rdata  out  DATA_W  registered debug read data
- dbg_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the completion cycle
- misalign_err  out  1  sticky flag for a pipeline access with addr[1:0] != 0

Behaviour:
- States:
  - IDLE: no access in flight.
  - BUSY: access in flight. Holds owner (PIPE or DBG) and down-counter cnt.
- Requests:
  - pipe_req = pipe_memread | pipe_memwrite. If both are set, the access is treated as a write.
  - dbg_eff = dbg_req & ~dbg_ack.
- Grant, IDLE only:
  - One requester pending: grant it.
  - Both pending: grant the requester other than last_grant (round-robin).
  - last_grant resets to DBG, so the pipeline wins the first conflict.
- At the grant edge:
  - Capture addr, wdata and we into registers.
  - Load cnt = MEM_LAT-1, enter BUSY, update last_grant.
- BUSY:
  - mem_en=1; mem_we/addr/wdata come from the captured registers and are stable for the whole access.
  - Decrement cnt each cycle. The completion cycle is cnt==0; at the next edge, return to IDLE.
- Completion, owner PIPE:
  - pipe_done=1 combinationally; pipe_rdata=mem_rdata for loads.
  - The MEM/WB register samples the result on that edge.
- Completion, owner DBG:
  - dbg_rdata <= mem_rdata for reads.
  - dbg_ack=1 for exactly the following cycle (registered).
- stall = pipe_req & ~pipe_done, combinational.
  - Load/store latency is MEM_LAT+1 cycles from first request visibility, with stall high MEM_LAT cycles.
  - Example: MEM_LAT=1 gives one stall cycle.
- Back-to-back pipeline accesses: a new pipe_req in the IDLE cycle after completion is granted that same cycle, with no bubble.
- Debug request arriving during pipeline BUSY: waits. It is granted in the next IDLE cycle if the pipeline does not also request, or by round-robin if it does.
- Pipeline inputs change while its access is in flight: the captured values are used. The pipeline is stalled, so this is not expected.
- misalign_err:
  - Set at grant of a pipeline access with pipe_addr[1:0] != 0; the access still proceeds.
  - Cleared only by reset.
- mem_en, mem_we: 0 in IDLE.
- Reset, at any time including mid-access:
  - Registers: state=IDLE, cnt=0, last_grant=DBG, captured regs=0, dbg_rdata=0, dbg_ack=0, misalign_err=0.
  - Combinational outputs: mem_en=0, mem_we=0, pipe_done=0, stall=0.
  - An in-flight access is abandoned and no ack is issued.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE, BUSY)
  - owner encoding (OWN_PIPE, OWN_DBG)
  - constant CNT_W = clog2(MEM_LAT)+1
- One sub-module, dmem_lat_counter: loadable down-counter with a zero flag, which the controller uses for the latency count.

Test Plan:
- MEM_LAT=2, pipe load to addr 0x10, mem returns 0xDEADBEEF:
  - stall high 2 cycles; mem_en high 2 cycles with mem_addr=0x10, mem_we=0
  - pipe_done and pipe_rdata=0xDEADBEEF in the 2nd BUSY cycle
- Pipe store then an immediate pipe load: the second grant is in the IDLE cycle right after completion, mem_we 1 then 0, no idle gap.
- pipe_req and dbg_req rise together from reset:
  - pipeline granted first; debug granted next
  - dbg_ack pulses once; dbg_rdata holds the memory value
- Debug write to 0x40 with data 0x12345678 while the pipeline is idle: mem_we=1, mem_wdata=0x12345678 for MEM_LAT cycles; dbg_ack pulses 1 cycle; no re-grant while dbg_req is still high in the ack cycle.
- Pipe load to 0x13: misalign_err sets and stays 1 through later aligned accesses until reset.
- reset asserted mid-BUSY:
  - mem_en, stall and dbg_ack go to 0 immediately
  - after release, state is IDLE and the next request is granted normally

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory access controller.
package dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

  // Latency counter width: enough to hold MEM_LAT-1 with one spare bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return $clog2(lat) + 1;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Bundle of pipeline, debug and data-memory signals around the MEM-stage access controller.
interface dmem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              pipe_memread;
  logic              pipe_memwrite;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_wdata;
  logic [DATA_W-1:0] pipe_rdata;
  logic              pipe_done;
  logic              stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              misalign_err;

  modport slave (
    input  pipe_memread, pipe_memwrite, pipe_addr, pipe_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  mem_rdata,
    output pipe_rdata, pipe_done, stall,
    output dbg_rdata, dbg_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output misalign_err
  );

  modport master (
    output pipe_memread, pipe_memwrite, pipe_addr, pipe_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output mem_rdata,
    input  pipe_rdata, pipe_done, stall,
    input  dbg_rdata, dbg_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  misalign_err
  );

endinterface

// File: rtl/dmem_lat_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module dmem_lat_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: arbitrates pipeline vs debug port, models fixed
// memory latency and stalls the pipeline until its access completes.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  dmem_access_ctrl_if.slave bus
);

  localparam int unsigned        CNT_W    = cnt_width(MEM_LAT);
  localparam logic [CNT_W-1:0]   LOAD_VAL = CNT_W'(MEM_LAT - 1);

  state_t            state;
  owner_t            owner;
  owner_t            last_grant;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic pipe_req;
  logic dbg_eff;
  logic busy;
  logic grant_pipe;
  logic grant_dbg;
  logic cnt_zero;
  logic done;

  assign pipe_req = bus.pipe_memread | bus.pipe_memwrite;
  // Masking with dbg_ack stops a still-high level request re-granting in the ack cycle.
  assign dbg_eff  = bus.dbg_req & ~bus.dbg_ack;
  assign busy     = (state == BUSY);

  assign grant_pipe = ~busy & pipe_req & (~dbg_eff | (last_grant == OWN_DBG));
  assign grant_dbg  = ~busy & dbg_eff & ~grant_pipe;
  assign done       = busy & cnt_zero;

  dmem_lat_counter #(
    .W(CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (grant_pipe | grant_dbg),
    .load_val (LOAD_VAL),
    .dec      (busy),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= OWN_DBG;
      last_grant       <= OWN_DBG;
      cap_we           <= 1'b0;
      cap_addr         <= '0;
      cap_wdata        <= '0;
      bus.dbg_rdata    <= '0;
      bus.dbg_ack      <= 1'b0;
      bus.misalign_err <= 1'b0;
    end else begin
      bus.dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_pipe) begin
            state      <= BUSY;
            owner      <= OWN_PIPE;
            last_grant <= OWN_PIPE;
            cap_we     <= bus.pipe_memwrite;
            cap_addr   <= bus.pipe_addr;
            cap_wdata  <= bus.pipe_wdata;
            if (bus.pipe_addr[1:0] != 2'b00) begin
              bus.misalign_err <= 1'b1;
            end
          end else if (grant_dbg) begin
            state      <= BUSY;
            owner      <= OWN_DBG;
            last_grant <= OWN_DBG;
            cap_we     <= bus.dbg_we;
            cap_addr   <= bus.dbg_addr;
            cap_wdata  <= bus.dbg_wdata;
          end
        end
        BUSY: begin
          if (cnt_zero) begin
            state <= IDLE;
            if (owner == OWN_DBG) begin
              bus.dbg_ack <= 1'b1;
              if (!cap_we) begin
                bus.dbg_rdata <= bus.mem_rdata;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en     = busy;
  assign bus.mem_we     = busy & cap_we;
  assign bus.mem_addr   = cap_addr;
  assign bus.mem_wdata  = cap_wdata;

  assign bus.pipe_done  = done & (owner == OWN_PIPE);
  assign bus.pipe_rdata = (bus.pipe_done && !cap_we) ? bus.mem_rdata : '0;
  // Reset term keeps stall low while reset is held even if a request is present.
  assign bus.stall      = pipe_req & ~bus.pipe_done & ~reset;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed + randomized bench for dmem_access_ctrl against a word-array memory model.
module tb_dmem_access_ctrl;

  localparam int M = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_access_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MEM_LAT (M)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Physical memory seen by the DUT, and the bench's transaction-level expectation.
  logic [31:0] mem_arr   [0:63];
  logic [31:0] model_mem [0:63];

  assign bus.mem_rdata = bus.mem_en ? mem_arr[bus.mem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.pipe_memread  = 1'b0;
    bus.pipe_memwrite = 1'b0;
    bus.pipe_addr     = 32'h0;
    bus.pipe_wdata    = 32'h0;
    bus.dbg_req       = 1'b0;
    bus.dbg_we        = 1'b0;
    bus.dbg_addr      = 32'h0;
    bus.dbg_wdata     = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One pipeline access; expects MEM_LAT stall cycles then a done cycle.
  task automatic pipe_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit drop);
    logic [31:0] exp_rd;
    exp_rd = model_mem[addr[7:2]];
    bus.pipe_memread  = rd;
    bus.pipe_memwrite = wr;
    bus.pipe_addr     = addr;
    bus.pipe_wdata    = wdata;
    for (int k = 0; k <= M; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("pipe_req_cycle_en", bus.mem_en, 0);
      end else begin
        check("pipe_busy_en", bus.mem_en, 1);
        check("pipe_busy_we", bus.mem_we, wr);
        check("pipe_busy_addr", bus.mem_addr, addr);
        if (wr) check("pipe_busy_wdata", bus.mem_wdata, wdata);
      end
      if (k < M) begin
        check("pipe_stall", bus.stall, 1);
        check("pipe_done_early", bus.pipe_done, 0);
      end else begin
        check("pipe_stall_release", bus.stall, 0);
        check("pipe_done", bus.pipe_done, 1);
        if (!wr) check("pipe_rdata", bus.pipe_rdata, exp_rd);
      end
      @(posedge clk);
      #1;
    end
    if (wr) model_mem[addr[7:2]] = wdata;
    if (drop) begin
      bus.pipe_memread  = 1'b0;
      bus.pipe_memwrite = 1'b0;
    end
  endtask

  // One debug access with the pipeline idle.
  task automatic dbg_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rd;
    exp_rd = model_mem[addr[7:2]];
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
    bus.dbg_req   = 1'b1;
    for (int c = 0; c <= M + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("dbg_req_cycle_en", bus.mem_en, 0);
        check("dbg_ack_early", bus.dbg_ack, 0);
      end else if (c <= M) begin
        check("dbg_busy_en", bus.mem_en, 1);
        check("dbg_busy_we", bus.mem_we, we);
        check("dbg_busy_addr", bus.mem_addr, addr);
        if (we) check("dbg_busy_wdata", bus.mem_wdata, wdata);
        check("dbg_no_stall", bus.stall, 0);
      end else begin
        check("dbg_ack", bus.dbg_ack, 1);
        check("dbg_ack_no_regrant", bus.mem_en, 0);
        if (!we) check("dbg_rdata", bus.dbg_rdata, exp_rd);
        bus.dbg_req = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("dbg_ack_single", bus.dbg_ack, 0);
    check("dbg_after_en", bus.mem_en, 0);
    @(posedge clk);
    #1;
    if (we) model_mem[addr[7:2]] = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout CHECKS %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] a1, a2, da, d, ra;
    bit          e_en, e_pd, e_ack, pipe_active;
    int          kind;

    reset = 1'b1;
    clear_inputs();
    bus.pipe_memread = 1'b1;
    #2;
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_pipe_done", bus.pipe_done, 0);
    do_reset();
    check("rst_dbg_ack", bus.dbg_ack, 0);
    check("rst_dbg_rdata", bus.dbg_rdata, 0);
    check("rst_misalign", bus.misalign_err, 0);

    // Load the memory through the debug port.
    for (int i = 0; i < 64; i++) begin
      d = (i == 4) ? 32'hDEADBEEF : $urandom;
      dbg_access(1'b1, 32'(i * 4), d);
    end

    // Pipeline and debug requests rise together from a fresh reset.
    do_reset();
    a1 = 32'h10;
    a2 = 32'h30;
    da = 32'h24;
    bus.pipe_memread = 1'b1;
    bus.pipe_addr    = a1;
    bus.dbg_req      = 1'b1;
    bus.dbg_we       = 1'b0;
    bus.dbg_addr     = da;
    for (int c = 0; c <= 3 * M + 2; c++) begin
      @(negedge clk);
      e_en  = (c >= 1 && c <= M) || (c >= M + 2 && c <= 2 * M + 1) ||
              (c >= 2 * M + 3 && c <= 3 * M + 2);
      e_pd  = (c == M) || (c == 3 * M + 2);
      e_ack = (c == 2 * M + 2);
      check("cf_mem_en", bus.mem_en, e_en);
      if (c >= 1 && c <= M) check("cf_addr_pipe1", bus.mem_addr, a1);
      if (c >= M + 2 && c <= 2 * M + 1) check("cf_addr_dbg", bus.mem_addr, da);
      if (c >= 2 * M + 3 && c <= 3 * M + 2) check("cf_addr_pipe2", bus.mem_addr, a2);
      check("cf_pipe_done", bus.pipe_done, e_pd);
      check("cf_dbg_ack", bus.dbg_ack, e_ack);
      check("cf_stall", bus.stall, !e_pd);
      if (c == M) check("cf_rdata1", bus.pipe_rdata, 32'hDEADBEEF);
      if (c == 2 * M + 2) begin
        check("cf_dbg_rdata", bus.dbg_rdata, model_mem[da[7:2]]);
        bus.dbg_req = 1'b0;
      end
      if (c == 3 * M + 2) check("cf_rdata2", bus.pipe_rdata, model_mem[a2[7:2]]);
      @(posedge clk);
      #1;
      if (c == M) bus.pipe_addr = a2;
      if (c == 3 * M + 2) bus.pipe_memread = 1'b0;
    end

    // Directed pipeline and debug transfers.
    pipe_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    d = $urandom;
    pipe_access(1'b0, 1'b1, 32'h20, d, 1'b0);
    pipe_access(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    dbg_access(1'b1, 32'h40, 32'h12345678);
    pipe_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
    check("aligned_no_misalign", bus.misalign_err, 0);

    // Randomized pipeline traffic with interleaved debug reads.
    pipe_active = 1'b0;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      ra   = {24'h0, 6'($urandom), 2'b00};
      d    = $urandom;
      if (kind == 3) begin
        if (pipe_active) begin
          bus.pipe_memread  = 1'b0;
          bus.pipe_memwrite = 1'b0;
          pipe_active = 1'b0;
        end
        dbg_access(1'b0, ra, 32'h0);
      end else begin
        pipe_access(kind != 1, kind != 0, ra, d, 1'($urandom));
        pipe_active = bus.pipe_memread | bus.pipe_memwrite;
        if (!pipe_active) begin
          @(negedge clk);
          check("rand_idle_en", bus.mem_en, 0);
          check("rand_idle_stall", bus.stall, 0);
          @(posedge clk);
          #1;
        end
      end
    end
    bus.pipe_memread  = 1'b0;
    bus.pipe_memwrite = 1'b0;
    @(posedge clk);
    #1;

    // Misaligned access is flagged but still performed; the flag is sticky.
    pipe_access(1'b1, 1'b0, 32'h13, 32'h0, 1'b1);
    check("misalign_set", bus.misalign_err, 1);
    pipe_access(1'b1, 1'b0, 32'h08, 32'h0, 1'b1);
    d = $urandom;
    pipe_access(1'b0, 1'b1, 32'h0C, d, 1'b1);
    dbg_access(1'b0, 32'h0C, 32'h0);
    check("misalign_sticky", bus.misalign_err, 1);

    // Reset in the middle of a debug access with the pipeline waiting.
    bus.dbg_req  = 1'b1;
    bus.dbg_we   = 1'b0;
    bus.dbg_addr = 32'h08;
    @(posedge clk);
    #1;
    bus.pipe_memread = 1'b1;
    bus.pipe_addr    = 32'h04;
    #1;
    check("mid_busy_en", bus.mem_en, 1);
    check("mid_busy_stall", bus.stall, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_en", bus.mem_en, 0);
    check("mid_rst_stall", bus.stall, 0);
    check("mid_rst_ack", bus.dbg_ack, 0);
    check("mid_rst_misalign", bus.misalign_err, 0);
    clear_inputs();
    repeat (2) begin
      @(negedge clk);
      check("in_rst_ack", bus.dbg_ack, 0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_ack", bus.dbg_ack, 0);
    check("post_rst_dbg_rdata", bus.dbg_rdata, 0);
    check("post_rst_en", bus.mem_en, 0);
    @(posedge clk);
    #1;
    pipe_access(1'b1, 1'b0, 32'h04, 32'h0, 1'b1);
    dbg_access(1'b0, 32'h08, 32'h0);
    check("post_rst_misalign", bus.misalign_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
